alu_issuer: RTL and testbench
=============================

# alu_issuer

Command-side driver for the team's registered 32-bit ALU (`a`, `b`, `op`, `en` in; `c` out, updated on the clock edge while `en` is high). It accepts operand/opcode commands over a valid/ready handshake and presents them to the ALU. It pulses the ALU enable for exactly one cycle, captures the registered result on the following cycle, and queues results in a small FIFO for a downstream consumer. It sits between a command source (test sequencer or controller) and one ALU instance.

## Interface
Parameters:
- `WIDTH`, 32 — operand/result width; must match the ALU.
- `DEPTH`, 4 — result FIFO entries; power of two, ≥ 2.

Ports:
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-high.
- `cmd_valid` in 1 — command offered.
- `cmd_ready` out 1 — command accepted when `cmd_valid && cmd_ready`.
- `cmd_a`, `cmd_b` in WIDTH — operands.
- `cmd_op` in 2 — 0 add, 1 sub, 2 and, 3 or.
- `alu_a`, `alu_b` out WIDTH; `alu_op` out 2; `alu_en` out 1 — drive the ALU.
- `alu_c` in WIDTH — ALU registered result.
- `res_valid` out 1; `res_ready` in 1; `res_data` out WIDTH — result stream.
- `res_count` out clog2(DEPTH)+1 — FIFO occupancy.
- `err` out 1 — sticky check failure (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: `cmd_ready = (res_count < DEPTH)`. On handshake, register `cmd_a/b/op` into `alu_a/b/op` and go to ISSUE. Otherwise stay.
- ISSUE: `alu_en = 1` for this cycle only; `cmd_ready = 0`; go to WAIT.
- WAIT: `alu_en = 0`, `cmd_ready = 0`; push `alu_c` into the FIFO at the cycle-end edge; go to IDLE.
- `alu_a/b/op` hold their last value outside IDLE handshakes.
- FIFO: push only in WAIT; pop on `res_valid && res_ready`. `res_valid = (res_count != 0)`. `res_data` = head entry. No fall-through.
- Simultaneous push and pop: `res_count` unchanged, ordering preserved.
- Overflow is impossible: a slot is guaranteed at acceptance, and only one command is in flight.
- Pop when empty: ignored. Pointers wrap modulo DEPTH.
- Arithmetic is ALU-defined; add/sub wrap modulo 2^WIDTH.

## Timing
- Handshake in cycle 0 → `alu_en = 1` in cycle 1 → `alu_c` valid in cycle 2 → `res_valid = 1` in cycle 3.
- Earliest next handshake: cycle 3. Throughput is one command per 3 cycles.
- Pop frees a slot visible to `cmd_ready` in the next cycle.
- Reset values: state IDLE, `alu_a = alu_b = 0`, `alu_op = 0`, `alu_en = 0`, `cmd_ready = 1` (FIFO empty), `res_valid = 0`, `res_data = 0` (storage cleared), `res_count = 0`, `err = 0`.
- Reset mid-operation: the in-flight command is dropped, the FIFO is emptied, and `alu_en` is 0 in the cycle after the reset edge.

## Configuration
- `ALU_ISSUER_CHECK_EN` defined:
  - An internal model computes the expected result from the latched `alu_a/b/op`.
  - In WAIT, a mismatch with `alu_c` sets `err` at the cycle-end edge.
  - `err` is sticky and cleared only by `reset`. The result is still pushed.
- Not defined: no model is built and `err` is tied to 0. The port list is identical in both builds.

## Test plan
- Reset, then `cmd_a=5, cmd_b=3, cmd_op=0` → `alu_en` high in cycle 1 only; `res_valid=1, res_data=8` in cycle 3; `cmd_ready=1` in cycle 3.
- Back-to-back ops, each checked for the stated `res_data`:
  - sub `a=0, b=1` → `0xFFFFFFFF`
  - and `0xF0F0, 0xFF00` → `0xF000`
  - or `0xF0F0, 0xFF00` → `0xFFF0`
  - Results come out in order.
- `res_ready=0`, offer 5 commands:
  - 4 accepted; `res_count=4`; `cmd_ready` stays 0 in IDLE.
  - Pop one → `cmd_ready=1` next cycle; 5th accepted.
- FIFO at count 2, `res_ready=1` during a WAIT push → `res_count` stays 2 and data order is preserved.
- Assert `reset` during ISSUE → next cycle `alu_en=0`, `res_valid=0`, `res_count=0`, state IDLE; a later command completes normally.
- With `ALU_ISSUER_CHECK_EN`, use an ALU stub returning `a+b+1`:
  - Add `2+2` → `res_data=5`, `err=1`; `err` stays 1 through further commands until `reset`.
  - Without the macro, `err=0` throughout.

Source files
------------

// File: rtl/alu_issuer.sv
// Command-side driver for a registered ALU: accepts one command at a time,
// pulses the ALU enable for one cycle, and queues results in a small FIFO.
// Optional build macro ALU_ISSUER_CHECK_EN adds a result checker driving err.
module alu_issuer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    input  logic [1:0]               cmd_op,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [1:0]               alu_op,
    output logic                     alu_en,
    input  logic [WIDTH-1:0]         alu_c,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [$clog2(DEPTH):0]   res_count,
    output logic                     err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [WIDTH-1:0]  alu_a_r;
    logic [WIDTH-1:0]  alu_b_r;
    logic [1:0]        alu_op_r;
    logic              alu_en_r;
    logic              cmd_ready_r;
    logic              res_valid_r;
    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;

    // Handshake and FIFO strobes decoded from registered state.
    always_comb begin
        accept_s = (state_r == IDLE) && cmd_valid && cmd_ready_r;
        push_s   = (state_r == WAIT);
        pop_s    = res_valid_r && res_ready;
    end

    // Next-state logic for the issue sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE:   state_s = WAIT;
            WAIT:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next FIFO occupancy; push and pop together leave it unchanged.
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CW'(1);
            2'b01:   count_s = count_r - CW'(1);
            default: count_s = count_r;
        endcase
    end

    // State, operand latches, FIFO storage and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            alu_a_r     <= {WIDTH{1'b0}};
            alu_b_r     <= {WIDTH{1'b0}};
            alu_op_r    <= 2'd0;
            alu_en_r    <= 1'b0;
            cmd_ready_r <= 1'b1;
            res_valid_r <= 1'b0;
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                alu_a_r  <= cmd_a;
                alu_b_r  <= cmd_b;
                alu_op_r <= cmd_op;
            end
            if (push_s) begin
                mem_r[wr_ptr_r] <= alu_c;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r     <= count_s;
            // Status flags are computed from next values so they stay registered.
            alu_en_r    <= (state_s == ISSUE);
            cmd_ready_r <= (state_s == IDLE) && (count_s < DEPTH_C);
            res_valid_r <= (count_s != {CW{1'b0}});
        end
    end

`ifdef ALU_ISSUER_CHECK_EN
    logic err_r;

    function automatic logic [WIDTH-1:0] alu_model(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [1:0]       op
    );
        logic [WIDTH-1:0] r;
        case (op)
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a & b;
            2'd3:    r = a | b;
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    // Sticky mismatch flag, evaluated when the result is captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (push_s && (alu_c != alu_model(alu_a_r, alu_b_r, alu_op_r))) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_op    = alu_op_r;
    assign alu_en    = alu_en_r;
    assign cmd_ready = cmd_ready_r;
    assign res_valid = res_valid_r;
    assign res_data  = mem_r[rd_ptr_r];
    assign res_count = count_r;

endmodule

// File: tb/tb_alu_issuer.sv
// Self-checking bench for alu_issuer: directed steps plus randomized commands,
// checked against a queue-based result model and a behavioural ALU.
module tb_alu_issuer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [WIDTH-1:0]  cmd_a;
    logic [WIDTH-1:0]  cmd_b;
    logic [1:0]        cmd_op;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [1:0]        alu_op;
    logic              alu_en;
    logic [WIDTH-1:0]  alu_c;
    logic              res_valid;
    logic              res_ready;
    logic [WIDTH-1:0]  res_data;
    logic [$clog2(DEPTH):0] res_count;
    logic              err;

    int                vectors = 0;
    int                miscompares = 0;
    logic [WIDTH-1:0]  exp_q[$];
    logic              alu_fault = 1'b0;
    logic              err_exp = 1'b0;

    alu_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_en(alu_en),
        .alu_c(alu_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_count(res_count), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_alu(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    // Behavioural registered ALU; the fault stub returns a+b+1.
    always @(posedge clk) begin
        if (alu_en) alu_c <= alu_fault ? (alu_a + alu_b + 32'd1) : ref_alu(alu_a, alu_b, alu_op);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] op);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
        step();
        cmd_valid = 1'b0;
        chk("issue_en", 32'(alu_en), 32'd1);
        chk("issue_a", alu_a, a);
        chk("issue_b", alu_b, b);
        chk("issue_op", 32'(alu_op), 32'(op));
        chk("issue_busy", 32'(cmd_ready), 32'd0);
        exp_q.push_back(alu_fault ? (a + b + 32'd1) : ref_alu(a, b, op));
        if (alu_fault) err_exp = 1'b1;
        step();
        chk("wait_en", 32'(alu_en), 32'd0);
        step();
        chk("done_count", 32'(res_count), 32'(exp_q.size()));
        chk("done_err", 32'(err), 32'(err_exp));
    endtask

    task automatic pop_check(input string tag);
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        if (exp_q.size() != 0) chk({tag, "_data"}, res_data, exp_q[0]);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = 2'd0; res_ready = 1'b0;
        step(); step();
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_en", 32'(alu_en), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_count", 32'(res_count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        step();

        // First command: 5+3 visible in cycle 3
        do_cmd(32'd5, 32'd3, 2'd0);
        chk("add_valid", 32'(res_valid), 32'd1);
        chk("add_data", res_data, 32'd8);
        chk("add_ready", 32'(cmd_ready), 32'd1);
        pop_check("add_pop");

        // Back-to-back sub/and/or, results in order
        do_cmd(32'd0, 32'd1, 2'd1);
        do_cmd(32'h0000F0F0, 32'h0000FF00, 2'd2);
        do_cmd(32'h0000F0F0, 32'h0000FF00, 2'd3);
        chk("sub_data", res_data, 32'hFFFFFFFF);
        pop_check("sub_pop");
        chk("and_data", res_data, 32'h0000F000);
        pop_check("and_pop");
        chk("or_data", res_data, 32'h0000FFF0);
        pop_check("or_pop");
        chk("empty_valid", 32'(res_valid), 32'd0);

        // Fill the FIFO, fifth command must stall until a pop
        for (int i = 0; i < 4; i++) do_cmd($urandom, $urandom, 2'($urandom_range(0, 3)));
        chk("full_count", 32'(res_count), 32'd4);
        cmd_valid = 1'b1; cmd_a = $urandom; cmd_b = $urandom; cmd_op = 2'($urandom_range(0, 3));
        for (int i = 0; i < 3; i++) begin
            chk("full_ready", 32'(cmd_ready), 32'd0);
            chk("full_no_en", 32'(alu_en), 32'd0);
            step();
        end
        chk("full_head", res_data, exp_q[0]);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        void'(exp_q.pop_front());
        chk("freed_ready", 32'(cmd_ready), 32'd1);
        chk("freed_count", 32'(res_count), 32'd3);
        exp_q.push_back(ref_alu(cmd_a, cmd_b, cmd_op));
        step();
        cmd_valid = 1'b0;
        chk("fifth_en", 32'(alu_en), 32'd1);
        step(); step();
        chk("fifth_count", 32'(res_count), 32'd4);
        while (exp_q.size() != 0) pop_check("drain");

        // Simultaneous push and pop at count 2
        do_cmd($urandom, $urandom, 2'd0);
        do_cmd($urandom, $urandom, 2'd1);
        cmd_valid = 1'b1; cmd_a = $urandom; cmd_b = $urandom; cmd_op = 2'd3;
        step();
        cmd_valid = 1'b0;
        step();
        chk("pp_head", res_data, exp_q[0]);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(ref_alu(cmd_a, cmd_b, cmd_op));
        chk("pp_count", 32'(res_count), 32'd2);
        pop_check("pp_order0");
        pop_check("pp_order1");

        // Reset during ISSUE
        do_cmd(32'd1, 32'd1, 2'd0);
        cmd_valid = 1'b1; cmd_a = 32'd7; cmd_b = 32'd9; cmd_op = 2'd0;
        step();
        cmd_valid = 1'b0;
        chk("mid_issue_en", 32'(alu_en), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        chk("mid_rst_en", 32'(alu_en), 32'd0);
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_count", 32'(res_count), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        step();
        chk("post_rst_en", 32'(alu_en), 32'd0);
        do_cmd(32'd100, 32'd23, 2'd1);
        chk("post_rst_data", res_data, 32'd77);
        pop_check("post_rst_pop");

        // Randomized commands with random draining
        for (int i = 0; i < 24; i++) begin
            do_cmd($urandom, $urandom, 2'($urandom_range(0, 3)));
            if (exp_q.size() == DEPTH || $urandom_range(0, 1) == 1) pop_check("rnd_pop");
            chk("rnd_count", 32'(res_count), 32'(exp_q.size()));
        end
        while (exp_q.size() != 0) pop_check("rnd_drain");

`ifdef ALU_ISSUER_CHECK_EN
        // Faulty ALU stub: error is sticky until reset
        alu_fault = 1'b1;
        do_cmd(32'd2, 32'd2, 2'd0);
        chk("fault_data", res_data, 32'd5);
        chk("fault_err", 32'(err), 32'd1);
        alu_fault = 1'b0;
        pop_check("fault_pop");
        do_cmd(32'd3, 32'd4, 2'd2);
        chk("sticky_err", 32'(err), 32'd1);
        pop_check("sticky_pop");
        reset = 1'b1;
        step();
        reset = 1'b0;
        err_exp = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);
`endif
        chk("final_err", 32'(err), 32'(err_exp));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
